// File: rtl/freelist_ckpt_pkg.sv
//----------------------------------------------------------------------------
// freelist_ckpt_pkg : shared defaults and rename-stage interface structs
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

package freelist_ckpt_pkg;

  localparam int DP_NUM_DEF     = 2;
  localparam int RT_NUM_DEF     = 2;
  localparam int PREG_NUM_DEF   = 64;
  localparam int ARCH_NUM_DEF   = 32;
  localparam int CKPT_NUM_DEF   = 4;
  localparam int PREG_IDX_WIDTH = $clog2(PREG_NUM_DEF);
  localparam int FL_ENTRY_NUM   = PREG_NUM_DEF - ARCH_NUM_DEF;
  localparam int DP_CNT_W       = $clog2(DP_NUM_DEF + 1);
  localparam int RT_CNT_W       = $clog2(RT_NUM_DEF + 1);
  localparam int CKPT_ID_W      = $clog2(CKPT_NUM_DEF);

  typedef logic [$clog2(FL_ENTRY_NUM):0] fl_ptr_t;

  typedef struct packed {
    logic [DP_CNT_W-1:0] dp_num;
  } DP_FL;

  typedef struct packed {
    logic [DP_CNT_W-1:0]                         avail_num;
    logic [DP_NUM_DEF-1:0][PREG_IDX_WIDTH-1:0]   tag;
  } FL_DP;

  typedef struct packed {
    logic [RT_CNT_W-1:0]                         rt_num;
    logic [RT_NUM_DEF-1:0][PREG_IDX_WIDTH-1:0]   phy_reg;
  } ROB_FL;

  typedef struct packed {
    logic                 save;
    logic [CKPT_ID_W-1:0] id;
    logic                 free;
    logic [CKPT_ID_W-1:0] free_id;
    logic                 rollback;
    logic [CKPT_ID_W-1:0] rb_id;
  } BR_FL;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fl_ckpt_table.sv
//----------------------------------------------------------------------------
// fl_ckpt_table : head-pointer checkpoint slots with per-slot valid bits
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module fl_ckpt_table
  import freelist_ckpt_pkg::*;
#(
  parameter int CKPT_NUM = CKPT_NUM_DEF,
  parameter int PTR_W    = 6
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_clear,
  input  logic                        i_save,
  input  logic [$clog2(CKPT_NUM)-1:0] i_save_id,
  input  logic [PTR_W-1:0]            i_save_ptr,
  input  logic                        i_free,
  input  logic [$clog2(CKPT_NUM)-1:0] i_free_id,
  input  logic                        i_restore,
  input  logic [$clog2(CKPT_NUM)-1:0] i_restore_id,
  output logic [PTR_W-1:0]            o_restore_ptr,
  output logic                        o_restore_hit,
  output logic                        o_save_ovw,
  output logic [CKPT_NUM-1:0]         o_valid
);

  logic [PTR_W-1:0]    r_ptr [CKPT_NUM];
  logic [CKPT_NUM-1:0] r_valid;

  assign o_restore_ptr = r_ptr[i_restore_id];
  assign o_restore_hit = r_valid[i_restore_id];
  assign o_save_ovw    = i_save & r_valid[i_save_id];
  assign o_valid       = r_valid;

  // Save is applied last so it wins over a same-slot free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < CKPT_NUM; i++) r_ptr[i] <= '0;
    end else if (i_clear) begin
      r_valid <= '0;
    end else begin
      if (i_free) r_valid[i_free_id] <= 1'b0;
      if (i_restore && r_valid[i_restore_id]) r_valid[i_restore_id] <= 1'b0;
      if (i_save) begin
        r_valid[i_save_id] <= 1'b1;
        r_ptr[i_save_id]   <= i_save_ptr;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/freelist_ckpt.sv
//----------------------------------------------------------------------------
// freelist_ckpt : multi-port physical-register free list with head checkpoints
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module freelist_ckpt
  import freelist_ckpt_pkg::*;
#(
  parameter int DP_NUM   = DP_NUM_DEF,
  parameter int RT_NUM   = RT_NUM_DEF,
  parameter int PREG_NUM = PREG_NUM_DEF,
  parameter int ARCH_NUM = ARCH_NUM_DEF,
  parameter int CKPT_NUM = CKPT_NUM_DEF
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [$clog2(DP_NUM+1)-1:0]          dp_num_i,
  output logic [DP_NUM*$clog2(PREG_NUM)-1:0]   dp_tag_o,
  output logic [$clog2(DP_NUM+1)-1:0]          avail_num_o,
  input  logic [$clog2(RT_NUM+1)-1:0]          rt_num_i,
  input  logic [RT_NUM*$clog2(PREG_NUM)-1:0]   rt_preg_i,
  input  logic                                 ckpt_save_i,
  input  logic [$clog2(CKPT_NUM)-1:0]          ckpt_id_i,
  input  logic                                 ckpt_free_i,
  input  logic [$clog2(CKPT_NUM)-1:0]          ckpt_free_id_i,
  input  logic                                 rollback_i,
  input  logic [$clog2(CKPT_NUM)-1:0]          rollback_id_i,
  input  logic                                 flush_i,
  output logic [CKPT_NUM-1:0]                  ckpt_valid_o,
  output logic                                 err_o
);

  localparam int ENTRY_NUM = PREG_NUM - ARCH_NUM;
  localparam int IDX_W     = $clog2(ENTRY_NUM);
  localparam int PTR_W     = IDX_W + 1;
  localparam int TAG_W     = $clog2(PREG_NUM);
  localparam int DPN_W     = $clog2(DP_NUM + 1);

  if ((ENTRY_NUM < 2) || ((ENTRY_NUM & (ENTRY_NUM - 1)) != 0)) begin : g_entry_chk
    $error("freelist_ckpt: PREG_NUM-ARCH_NUM must be a power of two");
  end

  logic [TAG_W-1:0] r_entry [ENTRY_NUM];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic             r_err;

  logic [PTR_W-1:0] w_count;
  logic [DPN_W-1:0] w_avail;
  logic [DPN_W-1:0] w_dp_eff;
  logic             w_dp_err;
  logic             w_rt_ovf;
  logic [PTR_W-1:0] w_tail_nxt;
  logic [PTR_W-1:0] w_head_alloc;
  logic [PTR_W-1:0] w_head_nxt;
  logic             w_dp_act;
  logic             w_rb;
  logic             w_rb_bad;
  logic             w_ck_hit;
  logic             w_save_ovw;
  logic [PTR_W-1:0] w_ck_ptr;
  logic [IDX_W-1:0] w_wr_idx [RT_NUM];

  for (genvar k = 0; k < DP_NUM; k++) begin : g_tag
    assign dp_tag_o[k*TAG_W +: TAG_W] = r_entry[IDX_W'(r_head[IDX_W-1:0] + IDX_W'(k))];
  end

  for (genvar k = 0; k < RT_NUM; k++) begin : g_wr
    assign w_wr_idx[k] = IDX_W'(r_tail[IDX_W-1:0] + IDX_W'(k));
  end

  assign w_count      = r_tail - r_head;
  assign w_avail      = DPN_W'(min_int(int'(w_count), DP_NUM));
  assign w_dp_err     = dp_num_i > w_avail;
  assign w_dp_eff     = w_dp_err ? w_avail : dp_num_i;
  assign w_rt_ovf     = (int'(w_count) + int'(rt_num_i)) > ENTRY_NUM;
  assign w_tail_nxt   = w_rt_ovf ? r_tail : r_tail + PTR_W'(rt_num_i);
  assign w_head_alloc = r_head + PTR_W'(w_dp_eff);

  // Flush outranks rollback, which in turn suppresses dispatch and save.
  assign w_dp_act = ~flush_i & ~rollback_i;
  assign w_rb     = rollback_i & ~flush_i;
  assign w_rb_bad = w_rb & ~w_ck_hit;

  always_comb begin
    w_head_nxt = w_head_alloc;
    if (flush_i)         w_head_nxt = w_tail_nxt - PTR_W'(ENTRY_NUM);
    else if (rollback_i) w_head_nxt = w_ck_hit ? w_ck_ptr : r_head;
  end

  fl_ckpt_table #(
    .CKPT_NUM (CKPT_NUM),
    .PTR_W    (PTR_W)
  ) u_ckpt (
    .i_clk         (clk_i),
    .i_rst_n       (rst_i),
    .i_clear       (flush_i),
    .i_save        (ckpt_save_i & w_dp_act),
    .i_save_id     (ckpt_id_i),
    .i_save_ptr    (w_head_alloc),
    .i_free        (ckpt_free_i & ~flush_i & ~w_rb_bad),
    .i_free_id     (ckpt_free_id_i),
    .i_restore     (w_rb),
    .i_restore_id  (rollback_id_i),
    .o_restore_ptr (w_ck_ptr),
    .o_restore_hit (w_ck_hit),
    .o_save_ovw    (w_save_ovw),
    .o_valid       (ckpt_valid_o)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRY_NUM; i++) r_entry[i] <= TAG_W'(ARCH_NUM + i);
      r_head <= '0;
      r_tail <= PTR_W'(ENTRY_NUM);
      r_err  <= 1'b0;
    end else begin
      if (!w_rt_ovf) begin
        for (int k = 0; k < RT_NUM; k++) begin
          if (k < int'(rt_num_i)) r_entry[w_wr_idx[k]] <= rt_preg_i[k*TAG_W +: TAG_W];
        end
      end
      r_tail <= w_tail_nxt;
      r_head <= w_head_nxt;
      r_err  <= r_err | w_rt_ovf | w_rb_bad | (w_dp_act & (w_dp_err | w_save_ovw));
    end
  end

  assign avail_num_o = w_avail;
  assign err_o       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_freelist_ckpt.sv
//----------------------------------------------------------------------------
// tb_freelist_ckpt : scoreboard bench with an unbounded-pointer ring model
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_freelist_ckpt;

  localparam int DP = 2;
  localparam int RT = 2;
  localparam int CK = 4;
  localparam int E  = 32;
  localparam int TW = 6;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [1:0]       dp_num_i = '0;
  logic [TW*DP-1:0] dp_tag_o;
  logic [1:0]       avail_num_o;
  logic [1:0]       rt_num_i = '0;
  logic [TW*RT-1:0] rt_preg_i = '0;
  logic             ckpt_save_i = 1'b0;
  logic [1:0]       ckpt_id_i = '0;
  logic             ckpt_free_i = 1'b0;
  logic [1:0]       ckpt_free_id_i = '0;
  logic             rollback_i = 1'b0;
  logic [1:0]       rollback_id_i = '0;
  logic             flush_i = 1'b0;
  logic [CK-1:0]    ckpt_valid_o;
  logic             err_o;

  always #5 clk_i = ~clk_i;

  freelist_ckpt u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .dp_num_i       (dp_num_i),
    .dp_tag_o       (dp_tag_o),
    .avail_num_o    (avail_num_o),
    .rt_num_i       (rt_num_i),
    .rt_preg_i      (rt_preg_i),
    .ckpt_save_i    (ckpt_save_i),
    .ckpt_id_i      (ckpt_id_i),
    .ckpt_free_i    (ckpt_free_i),
    .ckpt_free_id_i (ckpt_free_id_i),
    .rollback_i     (rollback_i),
    .rollback_id_i  (rollback_id_i),
    .flush_i        (flush_i),
    .ckpt_valid_o   (ckpt_valid_o),
    .err_o          (err_o)
  );

  typedef struct {
    int avail;
    int tag0;
    int tag1;
    int cv;
    int err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Model: absolute (never-wrapping) head/tail counters over a ring of tags.
  int mem[E];
  int hd, tl;
  int ck[CK];
  bit cvld[CK];
  bit merr;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < E; i++) mem[i] = 32 + i;
    hd = 0;
    tl = E;
    for (int i = 0; i < CK; i++) begin
      cvld[i] = 1'b0;
      ck[i]   = 0;
    end
    merr = 1'b0;
  endfunction

  function automatic void model_step(input int dp, input int rt, input int p0, input int p1,
                                     input bit sv, input int sid, input bit fr, input int fid,
                                     input bit rb, input int rbid, input bit fl);
    int cnt = tl - hd;
    int av  = (cnt < DP) ? cnt : DP;
    int eff;
    bit ovw;
    if (cnt + rt > E) merr = 1'b1;
    else begin
      if (rt > 0) mem[tl % E] = p0;
      if (rt > 1) mem[(tl + 1) % E] = p1;
      tl += rt;
    end
    if (fl) begin
      hd = tl - E;
      for (int i = 0; i < CK; i++) cvld[i] = 1'b0;
    end else if (rb) begin
      if (cvld[rbid]) begin
        hd = ck[rbid];
        cvld[rbid] = 1'b0;
        if (fr) cvld[fid] = 1'b0;
      end else merr = 1'b1;
    end else begin
      eff = (dp > av) ? av : dp;
      if (dp > av) merr = 1'b1;
      ovw = sv && cvld[sid];
      if (ovw) merr = 1'b1;
      if (fr) cvld[fid] = 1'b0;
      if (sv) begin
        cvld[sid] = 1'b1;
        ck[sid]   = hd + eff;
      end
      hd += eff;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int cnt = tl - hd;
    e.avail = (cnt < DP) ? cnt : DP;
    e.tag0  = mem[hd % E];
    e.tag1  = mem[(hd + 1) % E];
    e.cv    = 0;
    for (int i = 0; i < CK; i++) if (cvld[i]) e.cv |= (1 << i);
    e.err   = int'(merr);
    return e;
  endfunction

  // Monitor: outputs depend only on registered state, so sample at negedge.
  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("avail", int'(avail_num_o), mon_e.avail);
      check("tag0", int'(dp_tag_o[5:0]), mon_e.tag0);
      check("tag1", int'(dp_tag_o[11:6]), mon_e.tag1);
      check("ckpt_valid", int'(ckpt_valid_o), mon_e.cv);
      check("err", int'(err_o), mon_e.err);
    end
  end

  task automatic idle();
    dp_num_i = '0; rt_num_i = '0; rt_preg_i = '0;
    ckpt_save_i = 1'b0; ckpt_id_i = '0; ckpt_free_i = 1'b0; ckpt_free_id_i = '0;
    rollback_i = 1'b0; rollback_id_i = '0; flush_i = 1'b0;
  endtask

  task automatic step(input int dp, input int rt, input int p0, input int p1,
                      input bit sv, input int sid, input bit fr, input int fid,
                      input bit rb, input int rbid, input bit fl);
    @(negedge clk_i);
    dp_num_i        = dp[1:0];
    rt_num_i        = rt[1:0];
    rt_preg_i[5:0]  = p0[5:0];
    rt_preg_i[11:6] = p1[5:0];
    ckpt_save_i     = sv;
    ckpt_id_i       = sid[1:0];
    ckpt_free_i     = fr;
    ckpt_free_id_i  = fid[1:0];
    rollback_i      = rb;
    rollback_id_i   = rbid[1:0];
    flush_i         = fl;
    @(posedge clk_i);
    model_step(dp, rt, p0, p1, sv, sid, fr, fid, rb, rbid, fl);
    sb.push_back(model_out());
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2;
    idle();
    rst_i = 1'b0;
    #1;
    model_reset();
    sb.delete();
    check("rst_avail", int'(avail_num_o), 2);
    check("rst_tag0", int'(dp_tag_o[5:0]), 32);
    check("rst_tag1", int'(dp_tag_o[11:6]), 33);
    check("rst_ckpt_valid", int'(ckpt_valid_o), 0);
    check("rst_err", int'(err_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic run_random(input int n, input bit legal);
    int cnt, av, dp, rt, sid, fid, rbid, tla;
    bit sv, fr, rb, fl;
    for (int i = 0; i < n; i++) begin
      cnt  = tl - hd;
      av   = (cnt < DP) ? cnt : DP;
      dp   = legal ? int'($urandom_range(0, av)) : int'($urandom_range(0, 2));
      rt   = int'($urandom_range(0, 2));
      if (legal && cnt + rt > E) rt = E - cnt;
      sv   = ($urandom_range(0, 3) == 0);
      sid  = int'($urandom_range(0, 3));
      if (legal && cvld[sid]) sv = 1'b0;
      fr   = ($urandom_range(0, 3) == 0);
      fid  = int'($urandom_range(0, 3));
      rb   = ($urandom_range(0, 9) == 0);
      rbid = int'($urandom_range(0, 3));
      if (legal && !cvld[rbid]) rb = 1'b0;
      tla  = (cnt + rt > E) ? tl : tl + rt;
      if (rb && cvld[rbid] && (tla - ck[rbid] > E)) rb = 1'b0;
      fl   = ($urandom_range(0, 29) == 0);
      step(dp, rt, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
           sv, sid, fr, fid, rb, rbid, fl);
    end
  endtask

  initial begin
    idle();
    do_reset();

    // Reset mid-run after 5 dispatches.
    repeat (5) step(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Drain, over-request, retire into the wrap, simultaneous dispatch/retire.
    repeat (16) step(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 2, 8, 9, 0, 0, 0, 0, 0, 0, 0);
    step(2, 2, 10, 11, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Checkpoint save, rollback, then rollback to an invalid slot.
    step(2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Flush with retire in the same cycle, then keep dispatching.
    step(2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (4) step(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(2, 2, 5, 6, 1, 3, 0, 0, 1, 0, 1);
    step(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Retire into a full list.
    step(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    run_random(600, 1'b1);
    do_reset();
    run_random(600, 1'b0);

    repeat (3) @(negedge clk_i);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
